// File: rtl/bus_dma_arbiter.sv
// Bus arbiter between a CPU and a DMA engine sharing one external bus.
// The CPU is halted on a read cycle before DMA takes over; bursts are capped and followed by an optional CPU gap.
module bus_dma_arbiter #(
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned CPU_GAP   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_rnw,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        dma_req,
  input  logic        dma_rnw,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_dout,
  input  logic        dma_last,
  output logic        cpu_ready,
  output logic        dma_gnt,
  output logic        dma_ack,
  output logic        bus_rnw,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic [7:0]  halt_wait_cnt
);

  typedef enum logic [2:0] {
    CPU_OWN,
    HALT_WAIT,
    DMA_OWN,
    HANDBACK,
    COOLDOWN
  } state_t;

  localparam logic [8:0] BURST_LIMIT = 9'(MAX_BURST);
  localparam logic [7:0] GAP_LOAD    = 8'(CPU_GAP - 1);
  localparam bit         GAP_EN      = (CPU_GAP != 0);

  state_t     state, state_nxt;
  logic [7:0] burst_cnt;
  logic [7:0] cool_cnt;
  logic       cool_pend;
  logic       limit_hit;
  logic       dma_exit;

  assign dma_ack   = dma_gnt & dma_req;
  assign limit_hit = dma_ack && (({1'b0, burst_cnt} + 9'd1) == BURST_LIMIT);
  assign dma_exit  = (dma_ack && (dma_last || limit_hit)) || !dma_req;

  // dma_gnt is cleared asynchronously by rst, so the bus falls back to the CPU at once.
  assign bus_rnw  = dma_gnt ? dma_rnw  : cpu_rnw;
  assign bus_addr = dma_gnt ? dma_addr : cpu_addr;
  assign bus_dout = dma_gnt ? dma_dout : cpu_dout;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      CPU_OWN:   if (dma_req) state_nxt = HALT_WAIT;
      HALT_WAIT: begin
        if (!dma_req)     state_nxt = CPU_OWN;
        else if (cpu_rnw) state_nxt = DMA_OWN;
      end
      DMA_OWN:   if (dma_exit) state_nxt = HANDBACK;
      HANDBACK:  state_nxt = cool_pend ? COOLDOWN : CPU_OWN;
      COOLDOWN:  if (cool_cnt == 8'd0) state_nxt = CPU_OWN;
      default:   state_nxt = CPU_OWN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= CPU_OWN;
      cpu_ready     <= 1'b1;
      dma_gnt       <= 1'b0;
      burst_cnt     <= 8'd0;
      cool_cnt      <= 8'd0;
      cool_pend     <= 1'b0;
      halt_wait_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      cpu_ready <= (state_nxt == CPU_OWN) || (state_nxt == HANDBACK) || (state_nxt == COOLDOWN);
      dma_gnt   <= (state_nxt == DMA_OWN);

      if (state_nxt == DMA_OWN && state != DMA_OWN) burst_cnt <= 8'd0;
      else if (dma_ack)                             burst_cnt <= burst_cnt + 8'd1;

      // dma_last on the limiting ack ends the request outright, so no gap follows.
      if (state == DMA_OWN && dma_exit)
        cool_pend <= limit_hit && !dma_last && GAP_EN;

      if (state == HANDBACK && cool_pend)              cool_cnt <= GAP_LOAD;
      else if (state == COOLDOWN && cool_cnt != 8'd0)  cool_cnt <= cool_cnt - 8'd1;

      if (state_nxt == HALT_WAIT && state != HALT_WAIT)       halt_wait_cnt <= 8'd0;
      else if (state == HALT_WAIT && halt_wait_cnt != 8'hFF)  halt_wait_cnt <= halt_wait_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_bus_dma_arbiter.sv
// Self-checking bench for bus_dma_arbiter: directed scenarios plus a DMA transfer scoreboard.
module tb_bus_dma_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rnw;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        dma_req, dma_rnw, dma_last;
  logic [15:0] dma_addr;
  logic [7:0]  dma_dout;
  logic        cpu_ready, dma_gnt, dma_ack, bus_rnw;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout, halt_wait_cnt;

  typedef struct packed {
    logic        rnw;
    logic [15:0] addr;
    logic [7:0]  dout;
  } xfer_t;

  xfer_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    push_idx = 0;
  int    pres_idx = 0;

  logic        ready_s, gnt_s, ack_s;
  logic [15:0] bus_addr_s;
  logic [7:0]  bus_dout_s;

  bus_dma_arbiter #(.MAX_BURST(16), .CPU_GAP(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .dma_req(dma_req), .dma_rnw(dma_rnw), .dma_addr(dma_addr), .dma_dout(dma_dout),
    .dma_last(dma_last),
    .cpu_ready(cpu_ready), .dma_gnt(dma_gnt), .dma_ack(dma_ack),
    .bus_rnw(bus_rnw), .bus_addr(bus_addr), .bus_dout(bus_dout),
    .halt_wait_cnt(halt_wait_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic xfer_t xfer(input int idx);
    xfer_t x;
    x.rnw  = idx[0];
    x.addr = 16'(32'hA000 + idx * 3);
    x.dout = 8'(idx * 7 + 1);
    return x;
  endfunction

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      sb.push_back(xfer(push_idx));
      push_idx++;
    end
  endtask

  task automatic present();
    xfer_t x;
    x = xfer(pres_idx);
    dma_rnw  = x.rnw;
    dma_addr = x.addr;
    dma_dout = x.dout;
  endtask

  // One bus cycle: sample at the falling edge, score any ack, return just after the next rising edge.
  task automatic cyc();
    xfer_t e;
    @(negedge clk);
    ready_s    = cpu_ready;
    gnt_s      = dma_gnt;
    ack_s      = dma_ack;
    bus_addr_s = bus_addr;
    bus_dout_s = bus_dout;
    if (ack_s) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_ack", 32'(ack_s), 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_bus_addr", 32'(bus_addr), 32'(e.addr));
        check("sb_bus_dout", 32'(bus_dout), 32'(e.dout));
        check("sb_bus_rnw", 32'(bus_rnw), 32'(e.rnw));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input int last_idx, input int budget);
    int acks   = 0;
    int cycles = 0;
    while (acks < n && cycles < budget) begin
      present();
      dma_last = (acks == last_idx);
      cyc();
      cycles++;
      if (ack_s) begin
        acks++;
        pres_idx++;
      end
    end
    check("run_acks", 32'(acks), 32'(n));
    dma_last = 1'b0;
    present();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cpu_rnw = 1'b1; cpu_addr = 16'h1234; cpu_dout = 8'h56;
    dma_req = 1'b0; dma_last = 1'b0;
    present();
    #3;
    check("rst_ready", 32'(cpu_ready), 32'd1);
    check("rst_gnt", 32'(dma_gnt), 32'd0);
    check("rst_hwcnt", 32'(halt_wait_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Idle: CPU owns the bus throughout.
    for (int i = 0; i < 20; i++) begin
      cpu_addr = 16'($urandom);
      cpu_dout = 8'($urandom);
      cpu_rnw  = 1'($urandom);
      cyc();
      check("idle_ready", 32'(ready_s), 32'd1);
      check("idle_gnt", 32'(gnt_s), 32'd0);
      check("idle_bus_addr", 32'(bus_addr_s), 32'(cpu_addr));
      check("idle_bus_dout", 32'(bus_dout_s), 32'(cpu_dout));
    end

    // Write hold-off: three CPU write cycles in HALT_WAIT, then a read.
    cpu_rnw = 1'b1;
    push_n(3);
    dma_req = 1'b1;
    present();
    cyc();
    check("ho_t0_ready", 32'(ready_s), 32'd1);
    cpu_rnw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("ho_wr_ready", 32'(ready_s), 32'd0);
      check("ho_wr_gnt", 32'(gnt_s), 32'd0);
    end
    cpu_rnw = 1'b1;
    cyc();
    check("ho_rd_gnt", 32'(gnt_s), 32'd0);
    check("ho_gnt_after_read", 32'(dma_gnt), 32'd1);
    check("ho_hwcnt", 32'(halt_wait_cnt), 32'd4);

    // Early last on the third ack: HANDBACK, CPU_OWN, then straight back to HALT_WAIT.
    run(3, 2, 10);
    check("el_sb_empty", 32'(sb.size()), 32'd0);
    cyc();
    check("el_handback_ready", 32'(ready_s), 32'd1);
    check("el_handback_gnt", 32'(gnt_s), 32'd0);
    cyc();
    check("el_cpu_own_ready", 32'(ready_s), 32'd1);

    // Withdraw the request while in HALT_WAIT.
    dma_req = 1'b0;
    cyc();
    check("wd_halt_ready", 32'(ready_s), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("wd_ready", 32'(ready_s), 32'd1);
      check("wd_gnt", 32'(gnt_s), 32'd0);
    end
    check("wd_hwcnt", 32'(halt_wait_cnt), 32'd1);

    // Burst limit with a held request: 16 acks, handback, 4 cooldown cycles, CPU_OWN, HALT_WAIT.
    push_n(16);
    dma_req = 1'b1;
    present();
    cyc();
    check("lat_edge0_gnt", 32'(gnt_s), 32'd0);
    cyc();
    check("lat_edge1_gnt", 32'(gnt_s), 32'd0);
    check("lat_edge2_gnt", 32'(dma_gnt), 32'd1);
    run(16, -1, 40);
    check("bl_sb_empty", 32'(sb.size()), 32'd0);
    for (int i = 0; i < 7; i++) begin
      cyc();
      check("bl_gap_ready", 32'(ready_s), (i < 6) ? 32'd1 : 32'd0);
      check("bl_gap_gnt", 32'(gnt_s), 32'd0);
      check("bl_gap_ack", 32'(ack_s), 32'd0);
    end

    // Asynchronous reset during the fifth ack of the next grant.
    push_n(5);
    run(4, -1, 10);
    check("ar_pre_hwcnt", 32'(halt_wait_cnt), 32'd1);
    #1;
    check("ar_pre_ack", 32'(dma_ack), 32'd1);
    rst = 1'b1;
    #1;
    check("ar_gnt", 32'(dma_gnt), 32'd0);
    check("ar_ack", 32'(dma_ack), 32'd0);
    check("ar_ready", 32'(cpu_ready), 32'd1);
    check("ar_hwcnt", 32'(halt_wait_cnt), 32'd0);
    check("ar_bus_addr", 32'(bus_addr), 32'(cpu_addr));
    check("ar_bus_dout", 32'(bus_dout), 32'(cpu_dout));
    #1;
    rst = 1'b0;
    dma_req = 1'b0;
    check("ar_sb_left", 32'(sb.size()), 32'd1);
    sb.delete();
    pres_idx = push_idx;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("ar_post_ready", 32'(ready_s), 32'd1);
      check("ar_post_gnt", 32'(gnt_s), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
